// File: rtl/idli_decode_queue_pkg.sv
// Shared types for the decode queue: control bundle, queue entry and operand sources.
// Entry layout depends on IDLI_DECODE_IMM_FUSE_EN.
package idli_decode_queue_pkg;

    typedef logic [15:0] data_t;

    typedef enum logic [1:0] {SRC_REG, SRC_SQI, SRC_PC, SRC_ZERO} src_t;

    typedef enum logic [1:0] {PipeAlu, PipeCmp, PipeShift, PipeMem} pipe_t;
    typedef enum logic [1:0] {AluAdd, AluAnd, AluOr, AluXor} alu_op_t;
    typedef enum logic [1:0] {CmpEq, CmpNe, CmpLt, CmpLtu} cmp_op_t;
    typedef enum logic [1:0] {ShiftLsl, ShiftLsr, ShiftAsr, ShiftRor} shift_op_t;

    // A C field of all ones selects the trailing immediate as RHS.
    localparam logic [3:0] ImmField = 4'hF;

    typedef struct packed {
        pipe_t     pipe;
        alu_op_t   alu_op;
        logic      alu_inv;
        logic      alu_cin;
        cmp_op_t   cmp_op;
        shift_op_t shift_op;
        src_t      dst;
        src_t      lhs;
        src_t      rhs;
        src_t      aux;
        logic [3:0] dst_reg;
        logic [3:0] lhs_reg;
        logic [3:0] rhs_reg;
        logic [3:0] aux_reg;
        logic [2:0] cond;
        logic       cond_wr;
    } de_ctrl_t;

`ifdef IDLI_DECODE_IMM_FUSE_EN
    typedef struct packed {
        data_t enc;
        data_t imm;
    } dq_entry_t;
`else
    typedef struct packed {
        logic  is_imm;
        data_t enc;
    } dq_entry_t;
`endif

    function automatic logic need_imm(input de_ctrl_t ctrl);
        return ctrl.rhs == SRC_SQI;
    endfunction

endpackage

// File: rtl/idli_decode_queue_ctrl.sv
// Combinational pre-decode of a 16-bit encoding into the control bundle.
// Encoding fields: op [15:12], A [11:8], B [7:4], C [3:0]. Unaffected by IDLI_DECODE_IMM_FUSE_EN.
module idli_decode_ctrl_m
    import idli_decode_queue_pkg::*;
(
    input  data_t    enc,
    output de_ctrl_t ctrl
);

    logic [3:0] op, a, b, c;

    assign op = enc[15:12];
    assign a  = enc[11:8];
    assign b  = enc[7:4];
    assign c  = enc[3:0];

    always_comb begin
        ctrl = '0;
        ctrl.pipe     = pipe_t'(op[3:2]);
        ctrl.cmp_op   = cmp_op_t'(op[1:0]);
        ctrl.shift_op = shift_op_t'(op[1:0]);

        unique case (op[1:0])
            2'b00: ctrl.alu_op = AluAdd;
            2'b01: begin
                ctrl.alu_op  = AluAdd;
                ctrl.alu_inv = 1'b1;
                ctrl.alu_cin = 1'b1;
            end
            2'b10: ctrl.alu_op = AluAnd;
            2'b11: ctrl.alu_op = AluXor;
            default: ctrl.alu_op = AluAdd;
        endcase

        ctrl.dst_reg = a;
        ctrl.lhs     = (b == 4'h0) ? SRC_ZERO : SRC_REG;
        ctrl.lhs_reg = b;
        ctrl.rhs     = (c == ImmField) ? SRC_SQI : SRC_REG;
        ctrl.rhs_reg = (c == ImmField) ? 4'h0 : c;

        // Compares subtract and write a condition flag instead of a register.
        if (ctrl.pipe == PipeCmp) begin
            ctrl.alu_op  = AluAdd;
            ctrl.alu_inv = 1'b1;
            ctrl.alu_cin = 1'b1;
            ctrl.dst     = SRC_ZERO;
            ctrl.cond    = a[2:0];
            ctrl.cond_wr = 1'b1;
        end else begin
            ctrl.dst  = SRC_REG;
            ctrl.cond = 3'b111;
        end

        if (ctrl.pipe == PipeMem) begin
            ctrl.aux     = SRC_REG;
            ctrl.aux_reg = a;
        end else begin
            ctrl.aux     = SRC_ZERO;
            ctrl.aux_reg = 4'h0;
        end
    end

endmodule

// File: rtl/idli_decode_queue.sv
// Decode front end: assembles SQI chunks into words, pre-decodes and queues them for execute.
// IDLI_DECODE_IMM_FUSE_EN fuses an instruction with its trailing immediate into one entry.
module idli_decode_queue_m
    import idli_decode_queue_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                          i_dq_gck,
    input  logic                          i_dq_rst,
    input  logic [LANES-1:0]              i_dq_data,
    input  logic                          i_dq_valid,
    output logic                          o_dq_ready,
    input  logic                          i_dq_flush,
    input  logic                          i_dq_pop,
    output logic                          o_dq_valid,
    output logic [15:0]                   o_dq_enc,
`ifdef IDLI_DECODE_IMM_FUSE_EN
    output logic [15:0]                   o_dq_imm,
`else
    output logic                          o_dq_is_imm,
`endif
    output logic [$bits(de_ctrl_t)-1:0]   o_dq_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]    o_dq_count
);

    localparam int unsigned Beats = 16 / LANES;
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("LANES must be 1, 2, 4, 8 or 16");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    logic [3:0]      beat_q;
    logic [15:0]     asm_q;
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            imm_pend_q, imm_pend_d;
    dq_entry_t       mem_q [DEPTH];
    dq_entry_t       push_entry, head;
    data_t           word, head_dec_enc;
    de_ctrl_t        word_ctrl, head_ctrl;
    logic            accept, last_beat, word_done, push, pop;
`ifdef IDLI_DECODE_IMM_FUSE_EN
    data_t           stage_q, stage_d;
`endif

    assign pop        = i_dq_pop & o_dq_valid;
    assign o_dq_valid = count_q != '0;
    assign o_dq_ready = (count_q != CntW'(DEPTH)) | pop;
    assign accept     = i_dq_valid & o_dq_ready & ~i_dq_flush;
    assign last_beat  = beat_q == 4'(Beats - 1);
    assign word_done  = accept & last_beat;
    assign word       = (asm_q << LANES) | 16'(i_dq_data);

    idli_decode_ctrl_m u_word_dec (
        .enc  (word),
        .ctrl (word_ctrl)
    );

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        imm_pend_d = imm_pend_q;
`ifdef IDLI_DECODE_IMM_FUSE_EN
        stage_d    = stage_q;
        if (word_done) begin
            if (imm_pend_q) begin
                push           = 1'b1;
                push_entry.enc = stage_q;
                push_entry.imm = word;
                imm_pend_d     = 1'b0;
            end else if (need_imm(word_ctrl)) begin
                stage_d    = word;
                imm_pend_d = 1'b1;
            end else begin
                push           = 1'b1;
                push_entry.enc = word;
            end
        end
`else
        if (word_done) begin
            push              = 1'b1;
            push_entry.is_imm = imm_pend_q;
            push_entry.enc    = word;
            // An immediate word is never itself treated as wanting an immediate.
            imm_pend_d        = ~imm_pend_q & need_imm(word_ctrl);
        end
`endif
    end

    always_ff @(posedge i_dq_gck) begin
        if (i_dq_rst | i_dq_flush) begin
            beat_q     <= '0;
            asm_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            imm_pend_q <= 1'b0;
`ifdef IDLI_DECODE_IMM_FUSE_EN
            stage_q    <= '0;
`endif
        end else begin
            if (accept) begin
                asm_q  <= word;
                beat_q <= last_beat ? 4'h0 : beat_q + 4'h1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q    <= count_q + CntW'(push) - CntW'(pop);
            imm_pend_q <= imm_pend_d;
`ifdef IDLI_DECODE_IMM_FUSE_EN
            stage_q    <= stage_d;
`endif
        end
    end

    always_ff @(posedge i_dq_gck) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head     = mem_q[rd_ptr_q];
    assign o_dq_enc = o_dq_valid ? head.enc : 16'h0000;
`ifdef IDLI_DECODE_IMM_FUSE_EN
    assign o_dq_imm     = o_dq_valid ? head.imm : 16'h0000;
    assign head_dec_enc = o_dq_enc;
`else
    assign o_dq_is_imm  = o_dq_valid & head.is_imm;
    assign head_dec_enc = o_dq_is_imm ? 16'h0000 : o_dq_enc;
`endif

    idli_decode_ctrl_m u_head_dec (
        .enc  (head_dec_enc),
        .ctrl (head_ctrl)
    );

    assign o_dq_ctrl  = head_ctrl;
    assign o_dq_count = count_q;

endmodule

// File: tb/tb_idli_decode_queue_m.sv
// Directed bench for idli_decode_queue_m: LANES=4 main instance plus LANES=1 and LANES=16 sweeps.
module tb_idli_decode_queue_m;
    import idli_decode_queue_pkg::*;

    localparam int unsigned CtrlW = $bits(de_ctrl_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Main instance, LANES=4
    logic [3:0]       m_data = '0;
    logic             m_dvalid = 1'b0, m_flush = 1'b0, m_pop = 1'b0;
    logic             m_ready, m_valid;
    logic [15:0]      m_enc;
    logic [CtrlW-1:0] m_ctrl;
    logic [1:0]       m_count;
    de_ctrl_t         m_ctrl_s;
`ifdef IDLI_DECODE_IMM_FUSE_EN
    logic [15:0]      m_imm;
`else
    logic             m_is_imm;
`endif

    // LANES=1 instance
    logic [0:0]       a_data = '0;
    logic             a_dvalid = 1'b0, a_flush = 1'b0, a_pop = 1'b0;
    logic             a_ready, a_valid;
    logic [15:0]      a_enc;
    logic [CtrlW-1:0] a_ctrl;
    logic [1:0]       a_count;
`ifdef IDLI_DECODE_IMM_FUSE_EN
    logic [15:0]      a_imm;
`else
    logic             a_is_imm;
`endif

    // LANES=16 instance
    logic [15:0]      b_data = '0;
    logic             b_dvalid = 1'b0, b_flush = 1'b0, b_pop = 1'b0;
    logic             b_ready, b_valid;
    logic [15:0]      b_enc;
    logic [CtrlW-1:0] b_ctrl;
    logic [1:0]       b_count;
`ifdef IDLI_DECODE_IMM_FUSE_EN
    logic [15:0]      b_imm;
`else
    logic             b_is_imm;
`endif

    assign m_ctrl_s = de_ctrl_t'(m_ctrl);

    idli_decode_queue_m #(.LANES(4), .DEPTH(2)) u_dut (
        .i_dq_gck    (clk),
        .i_dq_rst    (rst),
        .i_dq_data   (m_data),
        .i_dq_valid  (m_dvalid),
        .o_dq_ready  (m_ready),
        .i_dq_flush  (m_flush),
        .i_dq_pop    (m_pop),
        .o_dq_valid  (m_valid),
        .o_dq_enc    (m_enc),
`ifdef IDLI_DECODE_IMM_FUSE_EN
        .o_dq_imm    (m_imm),
`else
        .o_dq_is_imm (m_is_imm),
`endif
        .o_dq_ctrl   (m_ctrl),
        .o_dq_count  (m_count)
    );

    idli_decode_queue_m #(.LANES(1), .DEPTH(2)) u_dut_l1 (
        .i_dq_gck    (clk),
        .i_dq_rst    (rst),
        .i_dq_data   (a_data),
        .i_dq_valid  (a_dvalid),
        .o_dq_ready  (a_ready),
        .i_dq_flush  (a_flush),
        .i_dq_pop    (a_pop),
        .o_dq_valid  (a_valid),
        .o_dq_enc    (a_enc),
`ifdef IDLI_DECODE_IMM_FUSE_EN
        .o_dq_imm    (a_imm),
`else
        .o_dq_is_imm (a_is_imm),
`endif
        .o_dq_ctrl   (a_ctrl),
        .o_dq_count  (a_count)
    );

    idli_decode_queue_m #(.LANES(16), .DEPTH(2)) u_dut_l16 (
        .i_dq_gck    (clk),
        .i_dq_rst    (rst),
        .i_dq_data   (b_data),
        .i_dq_valid  (b_dvalid),
        .o_dq_ready  (b_ready),
        .i_dq_flush  (b_flush),
        .i_dq_pop    (b_pop),
        .o_dq_valid  (b_valid),
        .o_dq_enc    (b_enc),
`ifdef IDLI_DECODE_IMM_FUSE_EN
        .o_dq_imm    (b_imm),
`else
        .o_dq_is_imm (b_is_imm),
`endif
        .o_dq_ctrl   (b_ctrl),
        .o_dq_count  (b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_beat(input logic [3:0] d);
        m_data   = d;
        m_dvalid = 1'b1;
        tick();
        m_dvalid = 1'b0;
    endtask

    task automatic m_word(input logic [15:0] w);
        for (int i = 0; i < 4; i++) m_beat(w[15-4*i -: 4]);
    endtask

    task automatic m_pop1;
        m_pop = 1'b1;
        tick();
        m_pop = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        de_ctrl_t    exp0;
        logic [15:0] w;

        // Hand decode of 16'h0000
        exp0          = '0;
        exp0.pipe     = PipeAlu;
        exp0.alu_op   = AluAdd;
        exp0.cmp_op   = CmpEq;
        exp0.shift_op = ShiftLsl;
        exp0.dst      = SRC_REG;
        exp0.lhs      = SRC_ZERO;
        exp0.rhs      = SRC_REG;
        exp0.aux      = SRC_ZERO;
        exp0.cond     = 3'b111;
        exp0.cond_wr  = 1'b0;

        tick();
        tick();
        chk("rst_valid", m_valid, 0);
        chk("rst_ready", m_ready, 1);
        chk("rst_count", m_count, 0);
        chk("rst_enc", m_enc, 0);
`ifdef IDLI_DECODE_IMM_FUSE_EN
        chk("rst_imm", m_imm, 0);
`else
        chk("rst_is_imm", m_is_imm, 0);
`endif
        chk("rst_ctrl", m_ctrl, exp0);
        rst = 1'b0;

        // Fill and hold
        m_beat(4'h0);
        m_beat(4'h1);
        m_beat(4'h2);
        m_data   = 4'h3;
        m_dvalid = 1'b1;
        #1;
        chk("fill_no_valid_before_last", m_valid, 0);
        tick();
        m_dvalid = 1'b0;
        chk("fill_valid", m_valid, 1);
        chk("fill_enc", m_enc, 16'h0123);
        chk("fill_count1", m_count, 1);
        m_word(16'h0456);
        chk("full_count", m_count, 2);
        chk("full_ready", m_ready, 0);
        chk("full_head", m_enc, 16'h0123);

        // Third word stalls on its first chunk until a pop
        m_data   = 4'h0;
        m_dvalid = 1'b1;
        tick();
        tick();
        tick();
        chk("stall_count", m_count, 2);
        chk("stall_ready", m_ready, 0);
        m_pop = 1'b1;
        #1;
        chk("pop_ready", m_ready, 1);
        tick();
        m_pop    = 1'b0;
        m_dvalid = 1'b0;
        chk("stall_pop_count", m_count, 1);
        chk("stall_pop_head", m_enc, 16'h0456);
        m_beat(4'h7);
        m_beat(4'h8);
        m_beat(4'h9);
        chk("third_count", m_count, 2);
        m_pop1();
        chk("third_head", m_enc, 16'h0789);
        chk("third_count1", m_count, 1);
        m_pop1();
        chk("drain_valid", m_valid, 0);
        chk("drain_enc", m_enc, 0);
        m_pop1();
        chk("underflow_count", m_count, 0);

        // Push and pop together leave a partly filled queue at the same count
        m_word(16'h1111);
        chk("pp_pre_count", m_count, 1);
        m_beat(4'h2);
        m_beat(4'h2);
        m_beat(4'h2);
        m_data   = 4'h2;
        m_dvalid = 1'b1;
        m_pop    = 1'b1;
        tick();
        m_dvalid = 1'b0;
        m_pop    = 1'b0;
        chk("pp_count", m_count, 1);
        chk("pp_head", m_enc, 16'h2222);
        m_pop1();

        // Trailing immediate
`ifdef IDLI_DECODE_IMM_FUSE_EN
        m_word(16'h012F);
        chk("fuse_staged_valid", m_valid, 0);
        chk("fuse_staged_count", m_count, 0);
        m_beat(4'hB);
        m_beat(4'hE);
        m_beat(4'hE);
        m_data   = 4'hF;
        m_dvalid = 1'b1;
        #1;
        chk("fuse_not_before_last", m_valid, 0);
        tick();
        m_dvalid = 1'b0;
        chk("fuse_count", m_count, 1);
        chk("fuse_enc", m_enc, 16'h012F);
        chk("fuse_imm", m_imm, 16'hBEEF);
        chk("fuse_rhs", m_ctrl_s.rhs, SRC_SQI);
        m_pop1();
        chk("fuse_drain", m_count, 0);
        m_word(16'h0123);
        chk("fuse_next_enc", m_enc, 16'h0123);
        chk("fuse_next_imm", m_imm, 0);
        m_pop1();
`else
        m_word(16'h012F);
        chk("imm_insn_count", m_count, 1);
        chk("imm_insn_enc", m_enc, 16'h012F);
        chk("imm_insn_flag", m_is_imm, 0);
        chk("imm_insn_rhs", m_ctrl_s.rhs, SRC_SQI);
        m_word(16'hBEEF);
        chk("imm_count", m_count, 2);
        m_pop1();
        chk("imm_enc", m_enc, 16'hBEEF);
        chk("imm_flag", m_is_imm, 1);
        chk("imm_ctrl", m_ctrl, exp0);
        m_pop1();
        m_word(16'h0123);
        chk("imm_next_flag", m_is_imm, 0);
        chk("imm_next_enc", m_enc, 16'h0123);
        m_pop1();
`endif

        // Flush mid-word with one entry queued; the chunk in the flush cycle is dropped
        m_word(16'h0123);
        chk("flush_pre_count", m_count, 1);
        m_beat(4'h0);
        m_beat(4'hA);
        m_data   = 4'hB;
        m_dvalid = 1'b1;
        m_flush  = 1'b1;
        tick();
        m_flush  = 1'b0;
        m_dvalid = 1'b0;
        chk("flush_count", m_count, 0);
        chk("flush_valid", m_valid, 0);
        chk("flush_ready", m_ready, 1);
        m_word(16'h4567);
        chk("flush_fresh_count", m_count, 1);
        chk("flush_fresh_enc", m_enc, 16'h4567);
        m_pop1();

        // LANES=1: sixteen beats per word
        w = 16'hA5C3;
        for (int i = 0; i < 15; i++) begin
            a_data   = w[15-i];
            a_dvalid = 1'b1;
            tick();
        end
        chk("l1_not_yet", a_valid, 0);
        a_data = w[0];
        tick();
        a_dvalid = 1'b0;
        chk("l1_valid", a_valid, 1);
        chk("l1_enc", a_enc, 16'hA5C3);
        chk("l1_count", a_count, 1);

        // LANES=16: one beat per word, then push+pop on a full queue
        b_data   = 16'hA5C3;
        b_dvalid = 1'b1;
        tick();
        b_dvalid = 1'b0;
        chk("l16_valid", b_valid, 1);
        chk("l16_enc", b_enc, 16'hA5C3);
        b_data   = 16'h1234;
        b_dvalid = 1'b1;
        tick();
        b_dvalid = 1'b0;
        chk("l16_full_count", b_count, 2);
        chk("l16_full_ready", b_ready, 0);
        b_data   = 16'h5678;
        b_dvalid = 1'b1;
        b_pop    = 1'b1;
        #1;
        chk("l16_pop_ready", b_ready, 1);
        tick();
        b_dvalid = 1'b0;
        b_pop    = 1'b0;
        chk("l16_pp_count", b_count, 2);
        chk("l16_pp_head", b_enc, 16'h1234);
        b_pop = 1'b1;
        tick();
        b_pop = 1'b0;
        chk("l16_third_head", b_enc, 16'h5678);
        chk("l16_third_count", b_count, 1);
        b_pop = 1'b1;
        tick();
        b_pop = 1'b0;
        chk("l16_empty", b_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/idli_decode_queue_m.md
# idli_decode_queue_m

Parametrised decode front end: assembles instruction words from the SQI stream `LANES` bits per cycle and pre-decodes each completed word. Decoded words are held in a `DEPTH`-entry FIFO with valid/pop handshakes to execute, so fetch runs ahead of execution instead of being tied to a fixed 4-cycle period. Trailing immediates are recognised (C field all ones, RHS = `SRC_SQI`) and handled explicitly. Sits between the SQI memory interface and the execution pipes.

## Interface
Parameters:
- `LANES`, 4, encoding bits received per cycle; legal values 1, 2, 4, 8, 16.
- `DEPTH`, 2, queue entries; power of two, at least 2.

Ports:
- `i_dq_gck`  in  1  clock.
- `i_dq_rst`  in  1  reset, synchronous, active-high.
- `i_dq_data`  in  LANES  next chunk of the encoding stream, most-significant chunk first.
- `i_dq_valid`  in  1  chunk present this cycle.
- `o_dq_ready`  out  1  chunk accepted if `i_dq_valid`.
- `i_dq_flush`  in  1  discard queue and partial word (redirect).
- `i_dq_pop`  in  1  consumer takes head entry; ignored when `o_dq_valid` is low.
- `o_dq_valid`  out  1  head entry valid.
- `o_dq_enc`  out  16  head encoding.
- `o_dq_imm`  out  16  head immediate; exists only with the macro.
- `o_dq_is_imm`  out  1  head is a raw immediate word; exists only without the macro.
- `o_dq_ctrl`  out  `$bits(de_ctrl_t)`  decoded control bundle for `o_dq_enc`.
- `o_dq_count`  out  `$clog2(DEPTH+1)`  occupied entries.

## Operation
- Beat counter runs 0 to 16/LANES-1. Each accepted chunk (`i_dq_valid & o_dq_ready`) shifts into the assembly register at the low end. The first chunk ends up in bits [15:16-LANES]. The word completes on the last beat.
- `o_dq_ready = (o_dq_count != DEPTH) | (i_dq_pop & o_dq_valid)`. This is a combinational path from pop to ready.
- A completed instruction word is decoded by the sub-module.
  - `need_imm` is true when the decoded RHS is `SRC_SQI`.
  - The `imm_pend` flag records that the next completed word is an immediate.
- Push target depends on `IDLI_DECODE_IMM_FUSE_EN` (see Configuration).
- Pop advances the read pointer. Push and pop in the same cycle leave the count unchanged, including when the queue is full.
- Flush has priority over push and pop. It clears:
  - read/write pointers, count, beat counter, `imm_pend`, and the staging register.
  - Any chunk presented in the flush cycle is dropped.
- Reset clears the same state as flush.
- Output values after reset:
  - `o_dq_valid` = 0, `o_dq_ready` = 1, `o_dq_count` = 0.
  - `o_dq_enc`, `o_dq_imm` and `o_dq_is_imm` = 0.
  - `o_dq_ctrl` = decode of 16'h0000.
  - Head data outputs are forced to 0 whenever `o_dq_valid` is low.
- Pointers wrap modulo `DEPTH`. There is no overflow: ready is low when full. There is no underflow: pop is ignored when empty.

## Timing
- Without stalls, a word takes 16/LANES accepted cycles.
- The last chunk is accepted in cycle N. The entry is visible at the head in cycle N+1 if the queue was empty.
- A fused instruction becomes visible in cycle N+1 after the last chunk of its immediate.
- After a pop in cycle N, the next entry is at the head in cycle N+1.
- Flush in cycle N gives `o_dq_valid` = 0 and `o_dq_count` = 0 in cycle N+1.

## Configuration
- `IDLI_DECODE_IMM_FUSE_EN` defined:
  - An instruction with `need_imm` waits in a staging register and is not pushed.
  - The following word is written as its immediate, and the combined entry is pushed as one entry.
  - Each entry is 32 bits wide, and the `o_dq_imm` port exists.
- Not defined:
  - Every word is pushed as its own entry. An immediate is tagged `is_imm`, with `o_dq_ctrl` = decode of 0.
  - Each entry is 17 bits wide, and the `o_dq_is_imm` port exists.

## Structure
- Shared package holds:
  - `de_ctrl_t`: packed pipe, ALU op/inv/cin, cmp op, shift op, dst/lhs/rhs/aux, and their regs, cond, cond_wr.
  - `dq_entry_t`.
  - Existing `src_t` and `data_t`.
- One sub-module, `idli_decode_ctrl_m`: purely combinational 16b encoding to `de_ctrl_t`. It is instantiated once on the assembled word (for `need_imm`) and once on the head entry (for `o_dq_ctrl`).
- Illegal `LANES` or `DEPTH` values raise an elaboration `$error`.

## Test plan
- Fill and hold (LANES=4, DEPTH=2): stream 16'h0123 then 16'h0456, no pop.
  - Response: valid in cycle 5, count 2, ready low.
  - A third word stalls until a pop, then pushes.
- Full push+pop:
  - Stimulus: pop on the cycle a third word completes.
  - Response: count stays 2, and the head sequence is 0123, 0456, then the new word.
- Immediate, macro on:
  - Stimulus: stream 16'h012F then 16'hBEEF.
  - Response: exactly one entry, enc=012F, imm=BEEF, visible 1 cycle after the 8th beat.
- Immediate, macro off:
  - Stimulus: same stream.
  - Response: two entries; the second has `is_imm`=1 and enc=BEEF.
- Flush mid-word:
  - Stimulus: flush after 2 of 4 beats with one entry queued.
  - Response: count 0 the next cycle; the next 4 chunks form a fresh word.
- Width sweep:
  - Stimulus: LANES=1 and LANES=16, stream 16'hA5C3 with no immediate.
  - Response: the entry appears after 16 cycles and after 1 cycle respectively; enc=A5C3 in both.
